// File: rtl/vram_scanout_if.sv
// VRAM video-port bundle: read enable and byte address out, read data back.
interface vram_scanout_if #(
    parameter int ADDRESS_WIDTH = 13
);
    logic                     o_mev;
    logic [ADDRESS_WIDTH-1:0] o_adrv;
    logic [7:0]               i_qv;

    modport master (
        output o_mev,
        output o_adrv,
        input  i_qv
    );

    modport slave (
        input  o_mev,
        input  o_adrv,
        output i_qv
    );
endinterface

// File: rtl/vram_scanout.sv
// 16-colour VRAM scanout: raster counters, nibble fetch, palette lookup,
// and sync/DE aligned to the two-cycle pixel pipeline.
module vram_scanout #(
    parameter int WIDTH         = 128,
    parameter int HEIGHT        = 128,
    parameter int SCALE         = 2,
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int SYNC_POL      = 0,
    parameter int ADDRESS_WIDTH = $clog2((WIDTH*HEIGHT+1)/2)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    vram_scanout_if.master        vram,
    input  logic                  i_pal_we,
    input  logic [3:0]            i_pal_idx,
    input  logic [23:0]           i_pal_rgb,
    output logic [23:0]           o_rgb,
    output logic                  o_de,
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic                  o_vblank_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SSH     = $clog2(SCALE);
    localparam int IW      = ADDRESS_WIDTH + 1;
    localparam logic SP    = (SYNC_POL != 0);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    logic                     mev_q, mev_d;
    logic [ADDRESS_WIDTH-1:0] adrv_q, adrv_d;
    logic                     act1_q, act1_d;
    logic                     sel1_q, sel1_d;
    logic                     hs1_q, hs1_d;
    logic                     vs1_q, vs1_d;
    logic                     vb1_q, vb1_d;

    logic [23:0] rgb_q, rgb_d;
    logic        de_q, de_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        vb_q, vb_d;

    logic [23:0] pal_q [16];
    logic [23:0] pal_d [16];

    logic [31:0]   hx, vx;
    logic          active, in_img;
    logic [IW-1:0] idx;
    logic [3:0]    nib;

    assign hx = 32'(h_q);
    assign vx = 32'(v_q);

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == HW'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
        end
    end

    // Stage 0: position decode and VRAM address issue
    always_comb begin
        active = (hx < H_ACTIVE) && (vx < V_ACTIVE);
        in_img = active && (hx < WIDTH * SCALE) && (vx < HEIGHT * SCALE);
        idx    = IW'(((vx >> SSH) * WIDTH) + (hx >> SSH));
        mev_d  = in_img;
        adrv_d = in_img ? idx[IW-1:1] : adrv_q;
        act1_d = active;
        sel1_d = idx[0];
        hs1_d  = ((hx >= H_ACTIVE + H_FP) &&
                  (hx <  H_ACTIVE + H_FP + H_SYNC)) ? SP : ~SP;
        vs1_d  = ((vx >= V_ACTIVE + V_FP) &&
                  (vx <  V_ACTIVE + V_FP + V_SYNC)) ? SP : ~SP;
        vb1_d  = (hx == 0) && (vx == V_ACTIVE);
    end

    // Stage 1 -> 2: nibble select and palette lookup
    always_comb begin
        nib   = sel1_q ? vram.i_qv[7:4] : vram.i_qv[3:0];
        rgb_d = mev_q ? pal_q[nib] : 24'h000000;
        de_d  = act1_q;
        hs_d  = hs1_q;
        vs_d  = vs1_q;
        vb_d  = vb1_q;
    end

    always_comb begin
        pal_d = pal_q;
        if (i_pal_we) begin
            pal_d[i_pal_idx] = i_pal_rgb;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_q    <= '0;
            v_q    <= '0;
            mev_q  <= 1'b0;
            adrv_q <= '0;
            act1_q <= 1'b0;
            sel1_q <= 1'b0;
            hs1_q  <= ~SP;
            vs1_q  <= ~SP;
            vb1_q  <= 1'b0;
            rgb_q  <= 24'h000000;
            de_q   <= 1'b0;
            hs_q   <= ~SP;
            vs_q   <= ~SP;
            vb_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                pal_q[i] <= {3{8'(i * 17)}};
            end
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            mev_q  <= mev_d;
            adrv_q <= adrv_d;
            act1_q <= act1_d;
            sel1_q <= sel1_d;
            hs1_q  <= hs1_d;
            vs1_q  <= vs1_d;
            vb1_q  <= vb1_d;
            rgb_q  <= rgb_d;
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            vb_q   <= vb_d;
            pal_q  <= pal_d;
        end
    end

    assign vram.o_mev     = mev_q;
    assign vram.o_adrv    = adrv_q;
    assign o_rgb          = rgb_q;
    assign o_de           = de_q;
    assign o_hsync        = hs_q;
    assign o_vsync        = vs_q;
    assign o_vblank_start = vb_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout on a tiny 14x9 raster with a 4x2 image scaled by 2.
// Expected outputs come from a position-based pixel model, two cycles behind.
module tb_vram_scanout;

    localparam int HT = 14;
    localparam int VT = 9;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_pal_we;
    logic [3:0]  i_pal_idx;
    logic [23:0] i_pal_rgb;
    logic [23:0] o_rgb;
    logic        o_de, o_hsync, o_vsync, o_vblank_start;

    always #5 clk = ~clk;

    vram_scanout_if #(.ADDRESS_WIDTH(2)) vif ();

    vram_scanout #(
        .WIDTH(4), .HEIGHT(2), .SCALE(2),
        .H_ACTIVE(10), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(0)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .vram           (vif),
        .i_pal_we       (i_pal_we),
        .i_pal_idx      (i_pal_idx),
        .i_pal_rgb      (i_pal_rgb),
        .o_rgb          (o_rgb),
        .o_de           (o_de),
        .o_hsync        (o_hsync),
        .o_vsync        (o_vsync),
        .o_vblank_start (o_vblank_start)
    );

    logic [7:0] vram [4];
    assign vif.i_qv = vram[vif.o_adrv];

    typedef struct packed {
        logic ok;
        int   h;
        int   v;
    } pos_t;

    pos_t        p0, p1, p2;
    logic [23:0] pal_m [16];
    logic [23:0] e_rgb;
    logic        e_de, e_hs, e_vs, e_vb, e_mev;
    logic [1:0]  e_adrv;

    int checks = 0;
    int errors = 0;
    int hs_low, vs_low, vb_cnt;

    function automatic bit act(pos_t p);
        return p.ok && p.h < 10 && p.v < 6;
    endfunction

    function automatic bit img(pos_t p);
        return act(p) && p.h < 8 && p.v < 4;
    endfunction

    function automatic int pidx(pos_t p);
        return (p.v / 2) * 4 + p.h / 2;
    endfunction

    function automatic logic [3:0] nib(int i);
        logic [7:0] b;
        b = vram[i / 2];
        return (i % 2 == 1) ? b[7:4] : b[3:0];
    endfunction

    function automatic pos_t nxt(pos_t p);
        pos_t n;
        n = p;
        n.h = p.h + 1;
        if (n.h == HT) begin
            n.h = 0;
            n.v = (p.v == VT - 1) ? 0 : p.v + 1;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("rgb", o_rgb, e_rgb);
        chk("de", o_de, e_de);
        chk("hsync", o_hsync, e_hs);
        chk("vsync", o_vsync, e_vs);
        chk("vblank_start", o_vblank_start, e_vb);
        chk("mev", vif.o_mev, e_mev);
        chk("adrv", vif.o_adrv, e_adrv);
    endtask

    // Advance one clock; the model is updated from inputs seen at the edge.
    task automatic step();
        bit          r  = i_rst;
        bit          we = i_pal_we;
        logic [3:0]  wi = i_pal_idx;
        logic [23:0] wd = i_pal_rgb;
        @(posedge clk);
        if (r) begin
            p0 = '{1'b1, 0, 0};
            p1.ok = 1'b0;
            p2.ok = 1'b0;
            for (int i = 0; i < 16; i++) pal_m[i] = {3{8'(i * 17)}};
            e_rgb = 24'h0; e_de = 0; e_hs = 1; e_vs = 1; e_vb = 0;
            e_mev = 0; e_adrv = 0;
        end else begin
            p2 = p1;
            p1 = p0;
            p0 = nxt(p0);
            e_de  = act(p2);
            e_rgb = img(p2) ? pal_m[nib(pidx(p2))] : 24'h0;
            e_hs  = !(p2.ok && p2.h >= 11 && p2.h < 13);
            e_vs  = !(p2.ok && p2.v == 7);
            e_vb  = p2.ok && p2.h == 0 && p2.v == 6;
            e_mev = img(p1);
            if (e_mev) e_adrv = 2'(pidx(p1) / 2);
            if (we) pal_m[wi] = wd;
        end
        @(negedge clk);
    endtask

    task automatic tick();
        chk_all();
        if (o_hsync === 1'b0) hs_low++;
        if (o_vsync === 1'b0) vs_low++;
        if (o_vblank_start === 1'b1) vb_cnt++;
        step();
        i_pal_we = 1'b0;
    endtask

    task automatic rand_write();
        if ($urandom_range(7) == 0) begin
            i_pal_we  = 1'b1;
            i_pal_idx = 4'($urandom_range(15));
            i_pal_rgb = 24'($urandom);
        end
    endtask

    task automatic clr_counts();
        hs_low = 0;
        vs_low = 0;
        vb_cnt = 0;
    endtask

    task automatic chk_counts();
        chk("hsync_low_cycles", hs_low, 18);
        chk("vsync_low_cycles", vs_low, 14);
        chk("vblank_pulses", vb_cnt, 1);
    endtask

    initial begin
        i_rst     = 1'b1;
        i_pal_we  = 1'b0;
        i_pal_idx = 4'h0;
        i_pal_rgb = 24'h0;
        p0 = '0; p1 = '0; p2 = '0;
        for (int i = 0; i < 4; i++) vram[i] = 8'($urandom);
        vram[0] = 8'h21;
        clr_counts();

        @(negedge clk);
        repeat (3) step();
        chk_all();
        i_rst = 1'b0;

        // Frame 1: grey palette, byte0 = 8'h21
        for (int c = 0; c < HT * VT; c++) begin
            if (c == 1) chk("de_pre_fill", o_de, 1'b0);
            if (c == 2) chk("de_rise", o_de, 1'b1);
            if (p2.ok && p2.v == 0 && p2.h < 2)
                chk("f1_pal1", o_rgb, 24'h111111);
            if (p2.ok && p2.v == 0 && p2.h >= 2 && p2.h < 4)
                chk("f1_pal2", o_rgb, 24'h222222);
            if (p1.ok && p1.v == 2 && p1.h == 0)
                chk("line2_adrv", vif.o_adrv, 2'd2);
            if (p2.ok && p2.v < 4 && (p2.h == 8 || p2.h == 9)) begin
                chk("border_de", o_de, 1'b1);
                chk("border_rgb", o_rgb, 24'h000000);
            end
            if (p0.h == 0 && p0.v == 7) begin
                i_pal_we  = 1'b1;
                i_pal_idx = 4'd1;
                i_pal_rgb = 24'hFF0000;
            end
            tick();
        end

        // Frame 2: new entry visible, collision write at the (0,0) lookup
        for (int i = 1; i < 4; i++) vram[i] = 8'($urandom);
        vram[0] = {4'($urandom), 4'h1};
        clr_counts();
        for (int c = 0; c < HT * VT; c++) begin
            if (p2.ok && p2.h == 0 && p2.v == 0)
                chk("f2_px00_old", o_rgb, 24'hFF0000);
            if (p2.ok && p2.h == 1 && p2.v == 0)
                chk("f2_px10_new", o_rgb, 24'h00FF00);
            if (p0.h == 1 && p0.v == 0) begin
                i_pal_we  = 1'b1;
                i_pal_idx = 4'd1;
                i_pal_rgb = 24'h00FF00;
            end
            tick();
        end
        chk_counts();

        // Frame 3: random image and random palette traffic
        for (int i = 0; i < 4; i++) vram[i] = 8'($urandom);
        clr_counts();
        for (int c = 0; c < HT * VT; c++) begin
            rand_write();
            tick();
        end
        chk_counts();

        // Frame 4: abort with a reset at h=5, v=3
        for (int c = 0; c < HT * VT; c++) begin
            if (p0.h == 5 && p0.v == 3) break;
            rand_write();
            tick();
        end
        chk("reset_point_h", p0.h, 5);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("rst_mev", vif.o_mev, 1'b0);
        chk("rst_de0", o_de, 1'b0);
        chk("rst_rgb0", o_rgb, 24'h0);
        tick();
        chk("rst_de1", o_de, 1'b0);
        chk("rst_rgb1", o_rgb, 24'h0);
        tick();
        chk("rst_de2", o_de, 1'b1);
        for (int c = 0; c < 2 * HT * VT; c++) begin
            rand_write();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
